// File: rtl/galaga_sched_pkg.sv
// galaga_sched_pkg: shared enums, movement pattern helpers and spawn constants
// for the enemy path sequencer.
`default_nettype none

package galaga_sched_pkg;

  typedef enum logic [1:0] {
    PAT_NOMOVE    = 2'd0,
    PAT_CIRCLE_X  = 2'd1,
    PAT_CIRCLE_Y  = 2'd2,
    PAT_BACKFORTH = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } sched_state_e;

  localparam int SPAWN_X0      = 20;
  localparam int SPAWN_X_PITCH = 60;
  localparam int SPAWN_Y       = 40;

  // Signed 3-bit delta for one pattern at one step; the caller sign-extends.
  function automatic logic signed [2:0] pattern_delta(pattern_e pat, int step, int nm);
    int q;
    q = nm / 4;
    pattern_delta = 3'b000;
    case (pat)
      PAT_CIRCLE_X:  pattern_delta = (step < q || step >= 3 * q) ? 3'b001 : 3'b111;
      PAT_CIRCLE_Y:  pattern_delta = (step < 2 * q) ? 3'b111 : 3'b001;
      PAT_BACKFORTH: pattern_delta = ((step % 2) != 0) ? 3'b010 : 3'b110;
      default:       pattern_delta = 3'b000;
    endcase
  endfunction

  function automatic pattern_e level_pattern_x(logic [2:0] level, int e);
    level_pattern_x = PAT_NOMOVE;
    case (level)
      3'd1: level_pattern_x = pattern_e'(2'(e + 1));
      3'd2: level_pattern_x = PAT_BACKFORTH;
      default: begin
        case (2'(e))
          2'd0:    level_pattern_x = PAT_CIRCLE_X;
          2'd1:    level_pattern_x = PAT_BACKFORTH;
          2'd2:    level_pattern_x = PAT_CIRCLE_Y;
          default: level_pattern_x = PAT_NOMOVE;
        endcase
      end
    endcase
  endfunction

  function automatic pattern_e level_pattern_y(logic [2:0] level, int e);
    level_pattern_y = PAT_NOMOVE;
    case (level)
      3'd1: level_pattern_y = pattern_e'(2'(e + 2));
      3'd2: level_pattern_y = PAT_NOMOVE;
      default: begin
        case (2'(e))
          2'd0:    level_pattern_y = PAT_CIRCLE_Y;
          2'd2:    level_pattern_y = PAT_CIRCLE_X;
          default: level_pattern_y = PAT_NOMOVE;
        endcase
      end
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/esched_step_timer.sv
// esched_step_timer: step divider and schedule counter; reports the step that a
// terminal divider count would present and whether it wraps to step 0.
`default_nettype none

module esched_step_timer #(
  parameter int NM       = 20,
  parameter int TICK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  run,
  output logic [$clog2(NM)-1:0] ctr,
  output logic [$clog2(NM)-1:0] ctr_next,
  output logic                  tick,
  output logic                  wrap
);

  localparam int CW   = $clog2(NM);
  localparam int DIVW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [DIVW-1:0] div;

  assign tick     = run && (div == DIVW'(TICK_DIV - 1));
  assign ctr_next = (ctr == CW'(NM - 1)) ? '0 : ctr + 1'b1;
  assign wrap     = tick && (ctr == CW'(NM - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
      ctr <= '0;
    end else if (clear) begin
      div <= '0;
      ctr <= '0;
    end else if (run) begin
      if (tick) begin
        div <= '0;
        ctr <= ctr_next;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/enemy_path_sequencer.sv
// enemy_path_sequencer: start/pause/stop schedule FSM driving per-enemy deltas,
// fire pulses and strobes. ESCHED_FIRE_STAGGER_EN selects one-enemy-per-step firing.
`default_nettype none

module enemy_path_sequencer #(
  parameter int NE        = 10,
  parameter int NM        = 20,
  parameter int DW        = 10,
  parameter int TICK_DIV  = 2,
  parameter int FIRE_STEP = 12
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [2:0]            CurrentLevel,
  input  logic                  Start,
  input  logic                  Pause,
  input  logic                  Stop,
  output logic [$clog2(NM)-1:0] ESchedCtr,
  output logic [NE*DW-1:0]      ESchedDX,
  output logic [NE*DW-1:0]      ESchedDY,
  output logic [NE-1:0]         ESchedFire,
  output logic [NE*DW-1:0]      EShipInitialX,
  output logic [NE*DW-1:0]      EShipInitialY,
  output logic                  StepStrobe,
  output logic                  LoopDone,
  output logic                  Busy
);

  import galaga_sched_pkg::*;

  localparam int CW = $clog2(NM);

  sched_state_e    state;
  logic [2:0]      level_q;
  logic [CW-1:0]   ctr_next;
  logic [CW-1:0]   pres_step;
  logic [2:0]      pres_level;
  logic            tick;
  logic            wrap;
  logic            timer_clear;
  logic            timer_run;
  logic [NE*DW-1:0] pres_dx;
  logic [NE*DW-1:0] pres_dy;
  logic [NE-1:0]   pres_fire;
  logic signed [2:0] dx_d;
  logic signed [2:0] dy_d;

  assign timer_clear = Start && !Stop;
  assign timer_run   = (state == ST_RUN) && !Stop && !Start && !Pause;

  esched_step_timer #(
    .NM       (NM),
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk      (Clk),
    .rst      (Reset),
    .clear    (timer_clear),
    .run      (timer_run),
    .ctr      (ESchedCtr),
    .ctr_next (ctr_next),
    .tick     (tick),
    .wrap     (wrap)
  );

  // Resuming from pause re-presents the current step's deltas without a strobe.
  assign pres_step  = Start ? '0 : ((state == ST_PAUSED) ? ESchedCtr : ctr_next);
  assign pres_level = (Start || wrap) ? CurrentLevel : level_q;

  always_comb begin
    pres_dx   = '0;
    pres_dy   = '0;
    pres_fire = '0;
    dx_d      = '0;
    dy_d      = '0;
    for (int e = 0; e < NE; e++) begin
      dx_d = pattern_delta(level_pattern_x(pres_level, e), int'(pres_step), NM);
      dy_d = pattern_delta(level_pattern_y(pres_level, e), int'(pres_step), NM);
      pres_dx[e*DW +: DW] = {{(DW-3){dx_d[2]}}, dx_d};
      pres_dy[e*DW +: DW] = {{(DW-3){dy_d[2]}}, dy_d};
`ifdef ESCHED_FIRE_STAGGER_EN
      pres_fire[e] = (int'(pres_step) == (FIRE_STEP + e) % NM);
`else
      pres_fire[e] = (int'(pres_step) == FIRE_STEP % NM) ||
                     (int'(pres_step) == (FIRE_STEP + 1) % NM) ||
                     (int'(pres_step) == (FIRE_STEP + 2) % NM);
`endif
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= ST_IDLE;
      level_q    <= '0;
      ESchedDX   <= '0;
      ESchedDY   <= '0;
      ESchedFire <= '0;
      StepStrobe <= 1'b0;
      LoopDone   <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      ESchedFire <= '0;
      StepStrobe <= 1'b0;
      LoopDone   <= 1'b0;
      if (Stop) begin
        state    <= ST_IDLE;
        ESchedDX <= '0;
        ESchedDY <= '0;
        Busy     <= 1'b0;
      end else if (Start) begin
        state      <= ST_RUN;
        level_q    <= CurrentLevel;
        ESchedDX   <= pres_dx;
        ESchedDY   <= pres_dy;
        ESchedFire <= pres_fire;
        StepStrobe <= 1'b1;
        Busy       <= 1'b1;
      end else begin
        case (state)
          ST_RUN: begin
            if (Pause) begin
              state    <= ST_PAUSED;
              ESchedDX <= '0;
              ESchedDY <= '0;
            end else if (tick) begin
              ESchedDX   <= pres_dx;
              ESchedDY   <= pres_dy;
              ESchedFire <= pres_fire;
              StepStrobe <= 1'b1;
              LoopDone   <= wrap;
              if (wrap) begin
                level_q <= CurrentLevel;
              end
            end
          end
          ST_PAUSED: begin
            if (!Pause) begin
              state    <= ST_RUN;
              ESchedDX <= pres_dx;
              ESchedDY <= pres_dy;
            end
          end
          default: begin
            state    <= ST_IDLE;
            ESchedDX <= '0;
            ESchedDY <= '0;
            Busy     <= 1'b0;
          end
        endcase
      end
    end
  end

  for (genvar e = 0; e < NE; e++) begin : g_spawn
    assign EShipInitialX[e*DW +: DW] = DW'(SPAWN_X0 + SPAWN_X_PITCH * e);
    assign EShipInitialY[e*DW +: DW] = DW'(SPAWN_Y);
  end

endmodule

`default_nettype wire

// File: tb/tb_enemy_path_sequencer.sv
// tb_enemy_path_sequencer: directed and randomized scenarios checked cycle by
// cycle against a step-level behavioural model of the schedule.
`default_nettype none

module tb_enemy_path_sequencer;

  localparam int NE = 10;
  localparam int NM = 20;
  localparam int DW = 10;
  localparam int TICK_DIV = 2;
  localparam int FIRE_STEP = 12;
  localparam int CW = $clog2(NM);
  localparam int AW = CW + 2*NE*DW + NE + 3;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic [2:0] CurrentLevel = '0;
  logic Start = 1'b0, Pause = 1'b0, Stop = 1'b0;
  logic [CW-1:0] ESchedCtr;
  logic [NE*DW-1:0] ESchedDX, ESchedDY, EShipInitialX, EShipInitialY;
  logic [NE-1:0] ESchedFire;
  logic StepStrobe, LoopDone, Busy;

  enemy_path_sequencer #(
    .NE(NE), .NM(NM), .DW(DW), .TICK_DIV(TICK_DIV), .FIRE_STEP(FIRE_STEP)
  ) dut (
    .Clk(Clk), .Reset(Reset), .CurrentLevel(CurrentLevel), .Start(Start),
    .Pause(Pause), .Stop(Stop), .ESchedCtr(ESchedCtr), .ESchedDX(ESchedDX),
    .ESchedDY(ESchedDY), .ESchedFire(ESchedFire), .EShipInitialX(EShipInitialX),
    .EShipInitialY(EShipInitialY), .StepStrobe(StepStrobe), .LoopDone(LoopDone),
    .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int passed = 0;

  // Model state: mode 0=idle 1=run 2=paused; phase = cycles spent in current step.
  int m_mode, m_step, m_phase, m_level;
  logic [CW-1:0] e_ctr;
  logic [NE*DW-1:0] e_dx, e_dy;
  logic [NE-1:0] e_fire;
  logic e_strobe, e_loop, e_busy;

  logic [AW-1:0] dut_all, exp_all;
  assign dut_all = {ESchedCtr, ESchedDX, ESchedDY, ESchedFire, StepStrobe, LoopDone, Busy};
  assign exp_all = {e_ctr, e_dx, e_dy, e_fire, e_strobe, e_loop, e_busy};

  function automatic int m_pat(int p, int s);
    int q = NM / 4;
    case (p)
      1: return (s < q || s >= 3*q) ? 1 : -1;
      2: return (s < 2*q) ? -1 : 1;
      3: return (s % 2 == 1) ? 2 : -2;
      default: return 0;
    endcase
  endfunction

  function automatic int m_xpat(int lvl, int e);
    int t0[4];
    t0 = '{1, 3, 2, 0};
    if (lvl == 1) return (e + 1) % 4;
    if (lvl == 2) return 3;
    return t0[e % 4];
  endfunction

  function automatic int m_ypat(int lvl, int e);
    int t0[4];
    t0 = '{2, 0, 1, 0};
    if (lvl == 1) return (e + 2) % 4;
    if (lvl == 2) return 0;
    return t0[e % 4];
  endfunction

  function automatic bit m_fires(int s, int e);
`ifdef ESCHED_FIRE_STAGGER_EN
    return s == (FIRE_STEP + e) % NM;
`else
    return (((s - FIRE_STEP) % NM) + NM) % NM < 3;
`endif
  endfunction

  task automatic model_present(int s, int lvl, bit with_fire);
    for (int e = 0; e < NE; e++) begin
      e_dx[e*DW +: DW] = DW'(m_pat(m_xpat(lvl, e), s));
      e_dy[e*DW +: DW] = DW'(m_pat(m_ypat(lvl, e), s));
      e_fire[e] = with_fire && m_fires(s, e);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_step = 0; m_phase = 0; m_level = 0;
    e_dx = '0; e_dy = '0; e_fire = '0;
    e_strobe = 0; e_loop = 0; e_busy = 0; e_ctr = '0;
  endtask

  task automatic model_edge(bit st, bit pa, bit sp, int lvl);
    e_fire = '0; e_strobe = 0; e_loop = 0;
    if (sp) begin
      m_mode = 0; e_dx = '0; e_dy = '0;
    end else if (st) begin
      m_mode = 1; m_step = 0; m_phase = 0; m_level = lvl;
      model_present(0, m_level, 1'b1);
      e_strobe = 1;
    end else if (m_mode == 1) begin
      if (pa) begin
        m_mode = 2; e_dx = '0; e_dy = '0;
      end else begin
        m_phase++;
        if (m_phase == TICK_DIV) begin
          m_phase = 0;
          m_step = (m_step + 1) % NM;
          if (m_step == 0) begin
            e_loop = 1; m_level = lvl;
          end
          model_present(m_step, m_level, 1'b1);
          e_strobe = 1;
        end
      end
    end else if (m_mode == 2 && !pa) begin
      m_mode = 1;
      model_present(m_step, m_level, 1'b0);
    end
    e_busy = (m_mode != 0);
    e_ctr = CW'(m_step);
  endtask

  task automatic cyc(bit st, bit pa, bit sp, int lvl);
    Start = st; Pause = pa; Stop = sp; CurrentLevel = 3'(lvl);
    @(posedge Clk);
    model_edge(st, pa, sp, lvl);
    #1;
  endtask

  task automatic test_reset();
    logic [NE*DW-1:0] sx, sy;
    Reset = 1; model_reset();
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if (dut_all !== '0) $display("FAIL reset_outputs: got %h want 0", dut_all); else passed++;
    for (int e = 0; e < NE; e++) begin
      sx[e*DW +: DW] = DW'(20 + 60*e);
      sy[e*DW +: DW] = DW'(40);
    end
    checks++;
    if ({EShipInitialX, EShipInitialY} !== {sx, sy})
      $display("FAIL spawn: got %h %h want %h %h", EShipInitialX, EShipInitialY, sx, sy);
    else passed++;
    Reset = 0;
    cyc(0, 0, 0, 0);
    checks++;
    if (dut_all !== exp_all) $display("FAIL idle_after_reset: got %h want %h", dut_all, exp_all); else passed++;
  endtask

  task automatic test_run_loop();
    int strobes = 0;
    bit saw19 = 0;
    cyc(1, 0, 0, 0);
    checks++;
    if (dut_all !== exp_all) $display("FAIL start_step0: got %h want %h", dut_all, exp_all); else passed++;
    checks++;
    if ({ESchedDX[0 +: DW], ESchedDY[0 +: DW], ESchedDX[DW +: DW]} !== {DW'(1), DW'(-1), DW'(-2)})
      $display("FAIL step0_deltas: got dx0=%h dy0=%h dx1=%h want 001 3ff 3fe",
               ESchedDX[0 +: DW], ESchedDY[0 +: DW], ESchedDX[DW +: DW]);
    else passed++;
    for (int i = 0; i < NM*TICK_DIV; i++) begin
      cyc(0, 0, 0, 0);
      strobes += int'(StepStrobe);
      if (ESchedCtr == CW'(19)) saw19 = 1;
      checks++;
      if (dut_all !== exp_all) $display("FAIL run_cycle%0d: got %h want %h", i, dut_all, exp_all); else passed++;
    end
    checks++;
    if (strobes != NM || !saw19) $display("FAIL loop_strobes: got %0d saw19=%0d want %0d 1", strobes, saw19, NM); else passed++;
    checks++;
    if ({LoopDone, ESchedCtr} !== {1'b1, CW'(0)}) $display("FAIL wrap: got loop=%b ctr=%0d want 1 0", LoopDone, ESchedCtr); else passed++;
  endtask

  task automatic test_fire();
    int full = 0;
    int f3 = 0;
    int f3_at15 = 0;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < NM*TICK_DIV; i++) begin
      cyc(0, 0, 0, 0);
      if (ESchedFire === {NE{1'b1}}) full++;
      if (ESchedFire[3]) begin
        f3++;
        if (ESchedCtr == CW'(15)) f3_at15++;
      end
      checks++;
      if (ESchedFire !== e_fire) $display("FAIL fire_cycle%0d: got %h want %h", i, ESchedFire, e_fire); else passed++;
    end
`ifdef ESCHED_FIRE_STAGGER_EN
    checks++;
    if (f3 != 1 || f3_at15 != 1) $display("FAIL fire3_stagger: got %0d/%0d want 1/1", f3, f3_at15); else passed++;
`else
    checks++;
    if (full != 3 || f3 != 3) $display("FAIL fire_window: got full=%0d f3=%0d want 3 3", full, f3); else passed++;
`endif
  endtask

  task automatic test_level_latch();
    logic [NE*DW-1:0] bf;
    int n = 0;
    cyc(1, 0, 0, 0);
    while (ESchedCtr != CW'(7) && n < 100) begin cyc(0, 0, 0, 0); n++; end
    if (n >= 100) begin checks++; $display("FAIL reach_step7: timeout got ctr=%0d want 7", ESchedCtr); end
    n = 0;
    do begin
      cyc(0, 0, 0, 2);
      n++;
      checks++;
      if (dut_all !== exp_all) $display("FAIL latch_cycle%0d: got %h want %h", n, dut_all, exp_all); else passed++;
    end while (!LoopDone && n < 100);
    if (n >= 100) begin checks++; $display("FAIL reach_wrap: timeout got ctr=%0d want 0", ESchedCtr); end
    for (int e = 0; e < NE; e++) bf[e*DW +: DW] = DW'(-2);
    checks++;
    if ({ESchedDX, ESchedDY} !== {bf, {NE*DW{1'b0}}}) $display("FAIL level2_step0: got %h %h want %h 0", ESchedDX, ESchedDY, bf); else passed++;
    repeat (TICK_DIV) cyc(0, 0, 0, 2);
    for (int e = 0; e < NE; e++) bf[e*DW +: DW] = DW'(2);
    checks++;
    if ({ESchedCtr, ESchedDX} !== {CW'(1), bf}) $display("FAIL level2_step1: got ctr=%0d dx=%h want 1 %h", ESchedCtr, ESchedDX, bf); else passed++;
  endtask

  task automatic test_pause();
    int n = 0;
    cyc(1, 0, 0, 0);
    while (ESchedCtr != CW'(4) && n < 100) begin cyc(0, 0, 0, 0); n++; end
    if (n >= 100) begin checks++; $display("FAIL reach_step4: timeout got ctr=%0d want 4", ESchedCtr); end
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 0);
      checks++;
      if ({ESchedCtr, ESchedDX, ESchedDY, StepStrobe, Busy} !== {CW'(4), {2*NE*DW{1'b0}}, 1'b0, 1'b1})
        $display("FAIL paused%0d: got ctr=%0d strobe=%b busy=%b dx=%h want 4 0 1 0", i, ESchedCtr, StepStrobe, Busy, ESchedDX);
      else passed++;
    end
    n = 0;
    do begin
      cyc(0, 0, 0, 0);
      n++;
      checks++;
      if (dut_all !== exp_all) $display("FAIL resume%0d: got %h want %h", n, dut_all, exp_all); else passed++;
    end while (!StepStrobe && n < 20);
    checks++;
    if (ESchedCtr !== CW'(5)) $display("FAIL resume_step5: got %0d want 5", ESchedCtr); else passed++;
  endtask

  task automatic test_start_stop();
    cyc(1, 0, 0, 1);
    repeat (5) cyc(0, 0, 0, 1);
    cyc(1, 0, 1, 1);
    checks++;
    if (Busy !== 1'b0 || dut_all !== exp_all) $display("FAIL start_stop: got busy=%b %h want 0 %h", Busy, dut_all, exp_all); else passed++;
    cyc(0, 0, 0, 1);
    checks++;
    if (dut_all !== exp_all) $display("FAIL idle_hold: got %h want %h", dut_all, exp_all); else passed++;
    cyc(1, 0, 0, 1);
    repeat (7) cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    checks++;
    if ({ESchedCtr, StepStrobe} !== {CW'(0), 1'b1} || dut_all !== exp_all)
      $display("FAIL restart: got ctr=%0d strobe=%b want 0 1", ESchedCtr, StepStrobe);
    else passed++;
  endtask

  task automatic test_async_reset();
    int n = 0;
    cyc(1, 0, 0, 0);
    while (ESchedCtr != CW'(9) && n < 100) begin cyc(0, 0, 0, 0); n++; end
    if (n >= 100) begin checks++; $display("FAIL reach_step9: timeout got ctr=%0d want 9", ESchedCtr); end
    cyc(0, 0, 0, 0);
    @(negedge Clk);
    Reset = 1;
    #1;
    model_reset();
    checks++;
    if (dut_all !== '0) $display("FAIL async_reset: got %h want 0", dut_all); else passed++;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 0;
    cyc(1, 0, 0, 0);
    checks++;
    if ({ESchedCtr, StepStrobe} !== {CW'(0), 1'b1} || dut_all !== exp_all)
      $display("FAIL start_after_reset: got %h want %h", dut_all, exp_all);
    else passed++;
  endtask

  task automatic test_random();
    bit st, pa, sp;
    int lvl;
    for (int i = 0; i < 800; i++) begin
      st = ($urandom_range(99) < 4);
      pa = ($urandom_range(99) < 15);
      sp = ($urandom_range(99) < 2);
      lvl = (i % 50 == 0) ? int'($urandom_range(7)) : int'(CurrentLevel);
      cyc(st, pa, sp, lvl);
      checks++;
      if (dut_all !== exp_all) $display("FAIL random%0d: got %h want %h", i, dut_all, exp_all); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_run_loop();
    test_fire();
    test_level_latch();
    test_pause();
    test_start_stop();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/enemy_path_sequencer.md
# enemy_path_sequencer

Parametrised successor to the enemy movement scheduler. It steps a shared schedule counter at a programmable rate and drives per-enemy signed X/Y move deltas and fire pulses. Deltas and fire pulses come from pattern tables chosen per level. Compared with the fixed scheduler it adds start/pause/stop control, a level latch that applies only at schedule wrap, step and loop strobes, and configurable enemy, step and width counts. It sits between game control (level, start/pause) and the enemy ship instances.

## Interface
- NE, 10, number of enemy ships
- NM, 20, steps per schedule loop; must be a multiple of 4 and at least 4
- DW, 10, width of position and delta words (two's complement)
- TICK_DIV, 2, Clk cycles per schedule step; must be at least 1
- FIRE_STEP, 12, first step of the fire window
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- CurrentLevel  in  3  level select
- Start  in  1  begin, or restart, the schedule at step 0
- Pause  in  1  level-sensitive freeze
- Stop  in  1  return to IDLE
- ESchedCtr  out  $clog2(NM)  current step index
- ESchedDX, ESchedDY  out  NE x DW  signed per-enemy delta for the current step
- ESchedFire  out  NE  per-enemy fire pulse, one cycle
- EShipInitialX, EShipInitialY  out  NE x DW  spawn coordinates (combinational constants)
- StepStrobe  out  1  one-cycle pulse each time a new step is presented
- LoopDone  out  1  one-cycle pulse when a step-0 wrap occurs
- Busy  out  1  high in RUN or PAUSED

## Operation
- FSM states: IDLE, RUN, PAUSED.
  - IDLE→RUN on Start.
  - RUN→PAUSED on Pause.
  - PAUSED→RUN when Pause drops.
  - Any state→IDLE on Stop.
  - Priority: Stop > Start > Pause.
- Start, in any state: ctr=0, divider=0, LevelQ=CurrentLevel, step 0 presented.
- Divider counts 0..TICK_DIV-1 in RUN only. At terminal count it presents the next step.
  - From NM-1 the next step is 0, with LoopDone, and LevelQ re-samples CurrentLevel.
  - A level change mid-loop therefore takes effect at the next wrap.
- PAUSED and IDLE freeze ctr and divider. DX, DY and Fire are forced to 0 and no strobes are issued.
- Presenting a step: ESchedCtr, DX, DY, Fire and StepStrobe are registered together. DX/DY/Fire correspond to the new ESchedCtr value. Between steps DX/DY hold; Fire and StepStrobe are 0.
- Patterns, with q=NM/4 and s = step:
  - NOMOVE = 0.
  - CIRCLE_X = +1 if s<q or s≥3q, else −1.
  - CIRCLE_Y = −1 if s<2q, else +1.
  - BACKFORTH = +2 on odd s, −2 on even s.
  - All values are sign-extended to DW.
- Level map: pattern for enemy e, using index order {NOMOVE, CIRCLE_X, CIRCLE_Y, BACKFORTH}.
  - Level 0: X cycles {CIRCLE_X, BACKFORTH, CIRCLE_Y, NOMOVE}[e%4]; Y cycles {CIRCLE_Y, NOMOVE, CIRCLE_X, NOMOVE}[e%4].
  - Level 1: X = pattern[(e+1)%4]; Y = pattern[(e+2)%4].
  - Level 2: X = BACKFORTH, Y = NOMOVE for all enemies.
  - Levels 3–7: same as level 0.
- Fire, baseline: every enemy fires on steps FIRE_STEP..FIRE_STEP+2, all taken mod NM.
- Spawn: InitialX = 20+60·e, InitialY = 40, truncated to DW.

## Timing
- Reset values: state IDLE, ESchedCtr=0, LevelQ=0, DX=DY=0, Fire=0, StepStrobe=0, LoopDone=0, Busy=0.
- Start sampled at edge N: at edge N, ctr=0, StepStrobe=1 and Busy=1 become visible. The next step follows TICK_DIV edges later.
- With TICK_DIV=1, StepStrobe is high every RUN cycle.
- Pause asserted at edge N: no step is presented at N. After Pause drops, the remaining divider count resumes unchanged.
- Reset asserted mid-operation: all outputs go to their reset values immediately (asynchronous). Reset release is synchronous to Clk.

## Configuration
- ESCHED_FIRE_STAGGER_EN:
  - Defined: enemy e fires only on step (FIRE_STEP+e) mod NM, one enemy per step.
  - Undefined: the baseline three-step common fire window.
- Movement behaviour is identical in both cases.

## Structure
- Package galaga_sched_pkg contains:
  - the pattern enum PAT_NOMOVE, PAT_CIRCLE_X, PAT_CIRCLE_Y, PAT_BACKFORTH;
  - the state enum;
  - the function pattern_delta(pat, step, NM);
  - the functions level_pattern_x/y(level, e);
  - the spawn constants.
- Sub-module esched_step_timer contains the divider, the step counter and the wrap/strobe generation. The top level holds the FSM, LevelQ and the output registers.

## Test plan
- Reset, then Start with level 0, NE=10, NM=20, TICK_DIV=2 → step 0: DX[0]=+1, DY[0]=−1, DX[1]=−2; StepStrobe every 2 cycles; ctr reaches 19, then 0 with LoopDone.
- Steps 12, 13, 14 → Fire = all ones on each of those three strobe cycles, 0 otherwise. With ESCHED_FIRE_STAGGER_EN defined → Fire[3] high only at step 15.
- CurrentLevel changed to 2 at step 7 → level 0 deltas continue until the wrap. From step 0 onward all DX=±2 alternating and all DY=0.
- Pause held for 5 cycles at step 4 → ctr stays 4, DX/DY=0, no strobes. After release, step 5 arrives after the remaining divider count.
- Start and Stop asserted together during RUN → IDLE, Busy=0. Start during RUN → ctr=0 with StepStrobe on the same edge.
- Reset asserted asynchronously mid-step 9 → all outputs 0 immediately. Start after release → step 0.
